// File: rtl/dp_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dp_controller_pkg
// Purpose  : State encodings and default widths for the datapath controller.
// Revision : 1.0 - initial release
// ============================================================================
package dp_controller_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 5;
    localparam int c_OP_W   = 3;
    localparam int c_CNT_W  = 16;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD_A = 3'd1;
    localparam logic [2:0] c_ST_LOAD_B = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_READ   = 3'd4;
    localparam logic [2:0] c_ST_RESP   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_LOAD_A = c_ST_LOAD_A,
        ST_LOAD_B = c_ST_LOAD_B,
        ST_EXEC   = c_ST_EXEC,
        ST_READ   = c_ST_READ,
        ST_RESP   = c_ST_RESP
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dp_controller.sv
`default_nettype none
// ============================================================================
// Module   : dp_controller
// Purpose  : Command sequencer stepping the register-file/ALU datapath through
//            load, execute/write-back and readback, then returning the value.
// Revision : 1.0 - initial release
// ============================================================================
module dp_controller
    import dp_controller_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W,
    parameter int OP_W   = c_OP_W,
    parameter int CNT_W  = c_CNT_W
) (
    input  logic              ctl_clk,
    input  logic              ctl_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rd_only,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] ctl_inp1,
    output logic [DATA_W-1:0] ctl_inp2,
    output logic              ctl_load1,
    output logic              ctl_load2,
    output logic [OP_W-1:0]   ctl_sel_alu,
    output logic [ADDR_W-1:0] ctl_WriteAddress,
    output logic [ADDR_W-1:0] ctl_ReadAddress,
    output logic              ctl_ReadWriteEn,
    output logic              ctl_done,
    input  logic [DATA_W-1:0] ctl_read_datapath,
    output logic [CNT_W-1:0]  ctl_cmd_count
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic [DATA_W-1:0]   r_cmd_b;
    logic [OP_W-1:0]     r_cmd_op;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [DATA_W-1:0]   r_inp1;
    logic [DATA_W-1:0]   r_inp2;
    logic [OP_W-1:0]     r_sel;
    logic [ADDR_W-1:0]   r_waddr;
    logic [ADDR_W-1:0]   r_raddr;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [CNT_W-1:0]    r_cnt;

    assign w_accept = (r_state == ST_IDLE) && cmd_valid;

    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (cmd_valid) w_state_nxt = cmd_rd_only ? ST_READ : ST_LOAD_A;
            ST_LOAD_A: w_state_nxt = ST_LOAD_B;
            ST_LOAD_B: w_state_nxt = ST_EXEC;
            ST_EXEC:   w_state_nxt = ST_READ;
            ST_READ:   w_state_nxt = ST_RESP;
            ST_RESP:   if (rsp_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Each datapath control value is updated on the edge entering the state
    // that strobes it, so it only changes when that strobe is about to fire.
    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            r_cmd_b    <= '0;
            r_cmd_op   <= '0;
            r_cmd_addr <= '0;
            r_inp1     <= '0;
            r_inp2     <= '0;
            r_sel      <= '0;
            r_waddr    <= '0;
            r_raddr    <= '0;
            r_rsp_data <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_accept) begin
                r_cmd_b    <= cmd_b;
                r_cmd_op   <= cmd_op;
                r_cmd_addr <= cmd_addr;
                if (cmd_rd_only) begin
                    r_raddr <= cmd_addr;
                end else begin
                    r_inp1 <= cmd_a;
                end
            end
            if (r_state == ST_LOAD_A) begin
                r_inp2 <= r_cmd_b;
            end
            if (r_state == ST_LOAD_B) begin
                r_sel   <= r_cmd_op;
                r_waddr <= r_cmd_addr;
            end
            if (r_state == ST_EXEC) begin
                r_raddr <= r_cmd_addr;
            end
            if (r_state == ST_READ) begin
                r_rsp_data <= ctl_read_datapath;
            end
            if ((r_state == ST_RESP) && rsp_ready) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign cmd_ready        = (r_state == ST_IDLE);
    assign ctl_load1        = (r_state == ST_LOAD_A);
    assign ctl_load2        = (r_state == ST_LOAD_B);
    // Reset forces read mode so an in-flight EXEC cannot write on the reset edge.
    assign ctl_ReadWriteEn  = ctl_reset || (r_state != ST_EXEC);
    assign rsp_valid        = (r_state == ST_RESP);
    assign ctl_done         = (r_state == ST_RESP);
    assign ctl_inp1         = r_inp1;
    assign ctl_inp2         = r_inp2;
    assign ctl_sel_alu      = r_sel;
    assign ctl_WriteAddress = r_waddr;
    assign ctl_ReadAddress  = r_raddr;
    assign rsp_data         = r_rsp_data;
    assign ctl_cmd_count    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dp_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_controller
// Purpose  : Directed self-checking bench for dp_controller with a datapath model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_controller;

    logic        tb_clk = 1'b0;
    logic        ctl_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rd_only;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [4:0]  cmd_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] ctl_inp1;
    logic [31:0] ctl_inp2;
    logic        ctl_load1;
    logic        ctl_load2;
    logic [2:0]  ctl_sel_alu;
    logic [4:0]  ctl_WriteAddress;
    logic [4:0]  ctl_ReadAddress;
    logic        ctl_ReadWriteEn;
    logic        ctl_done;
    logic [31:0] ctl_read_datapath;
    logic [1:0]  ctl_cmd_count;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 tb_clk = ~tb_clk;

    dp_controller #(
        .DATA_W(32), .ADDR_W(5), .OP_W(3), .CNT_W(2)
    ) u_dut (
        .ctl_clk          (tb_clk),
        .ctl_reset        (ctl_reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_rd_only      (cmd_rd_only),
        .cmd_op           (cmd_op),
        .cmd_a            (cmd_a),
        .cmd_b            (cmd_b),
        .cmd_addr         (cmd_addr),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .ctl_inp1         (ctl_inp1),
        .ctl_inp2         (ctl_inp2),
        .ctl_load1        (ctl_load1),
        .ctl_load2        (ctl_load2),
        .ctl_sel_alu      (ctl_sel_alu),
        .ctl_WriteAddress (ctl_WriteAddress),
        .ctl_ReadAddress  (ctl_ReadAddress),
        .ctl_ReadWriteEn  (ctl_ReadWriteEn),
        .ctl_done         (ctl_done),
        .ctl_read_datapath(ctl_read_datapath),
        .ctl_cmd_count    (ctl_cmd_count)
    );

    // Datapath model: operand registers, ALU, register file without reset.
    logic [31:0] m_rf [32];
    logic [31:0] m_op1 = '0;
    logic [31:0] m_op2 = '0;
    logic [31:0] w_alu;

    always_comb begin
        w_alu = '0;
        case (ctl_sel_alu)
            3'b000:  w_alu = m_op1 + m_op2;
            3'b101:  w_alu = m_op1 - m_op2;
            default: w_alu = '0;
        endcase
    end

    initial begin
        for (int i = 0; i < 32; i++) m_rf[i] = 32'(i * 17);
    end

    always @(posedge tb_clk) begin
        if (ctl_load1) m_op1 <= ctl_inp1;
        if (ctl_load2) m_op2 <= ctl_inp2;
        if (!ctl_ReadWriteEn) m_rf[ctl_WriteAddress] <= w_alu;
    end

    assign ctl_read_datapath = m_rf[ctl_ReadAddress];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    // One command from IDLE through handshake; stall = rsp_ready-low cycles in RESP.
    task automatic do_cmd(input logic rd, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] addr,
                          input logic [31:0] exp_data, input int stall,
                          input logic [1:0] exp_cnt);
        cmd_valid = 1'b1; cmd_rd_only = rd; cmd_op = op;
        cmd_a = a; cmd_b = b; cmd_addr = addr;
        step();
        cmd_valid = 1'b0;
        if (!rd) begin
            check_eq("load_a", {ctl_load1, ctl_load2, ctl_ReadWriteEn, ctl_inp1}, {3'b101, a});
            step();
            check_eq("load_b", {ctl_load1, ctl_load2, ctl_ReadWriteEn, ctl_inp2}, {3'b011, b});
            step();
            check_eq("exec", {ctl_load1, ctl_load2, ctl_ReadWriteEn, ctl_sel_alu, ctl_WriteAddress},
                     {3'b000, op, addr});
            step();
        end
        check_eq("read", {rsp_valid, ctl_load1, ctl_load2, ctl_ReadWriteEn, ctl_ReadAddress},
                 {4'b0001, addr});
        step();
        check_eq("resp", {rsp_valid, ctl_done, cmd_ready, rsp_data}, {3'b110, exp_data});
        for (int s = 0; s < stall; s++) begin
            cmd_valid = s[0];
            cmd_a = 32'hDEAD_0000;
            step();
            check_eq("stall", {rsp_valid, cmd_ready, rsp_data}, {2'b10, exp_data});
        end
        // A command offered in the completing cycle must not be captured.
        rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_rd_only = 1'b1; cmd_addr = 5'd0;
        step();
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        check_eq("complete", {rsp_valid, ctl_done, cmd_ready, 30'(ctl_cmd_count)},
                 {3'b001, 30'(exp_cnt)});
    endtask

    initial begin
        ctl_reset = 1'b1; cmd_valid = 1'b0; cmd_rd_only = 1'b0; cmd_op = '0;
        cmd_a = '0; cmd_b = '0; cmd_addr = '0; rsp_ready = 1'b0;
        step();
        step();
        check_eq("rst_ctl", {ctl_load1, ctl_load2, ctl_done, rsp_valid, ctl_ReadWriteEn},
                 {5'b00001});
        check_eq("rst_data", {ctl_inp1 | ctl_inp2 | rsp_data}, 32'h0);
        check_eq("rst_addr", {ctl_sel_alu, ctl_WriteAddress, ctl_ReadAddress, ctl_cmd_count},
                 32'h0);
        ctl_reset = 1'b0;
        step();
        check_eq("ready_after_rst", {31'h0, cmd_ready}, 32'h1);

        do_cmd(1'b0, 3'b000, 32'd0, 32'd5, 5'd1, 32'd5, 0, 2'd1);
        do_cmd(1'b1, 3'b000, 32'd0, 32'd0, 5'd1, 32'd5, 0, 2'd2);
        do_cmd(1'b0, 3'b000, 32'd10, 32'd20, 5'd3, 32'd30, 4, 2'd3);

        // Abort a write to addr 2 while in EXEC.
        cmd_valid = 1'b1; cmd_rd_only = 1'b0; cmd_op = 3'b000;
        cmd_a = 32'd7; cmd_b = 32'd3; cmd_addr = 5'd2;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check_eq("abort_in_exec", {31'h0, ctl_ReadWriteEn}, 32'h0);
        ctl_reset = 1'b1;
        #1;
        check_eq("abort_rwen", {31'h0, ctl_ReadWriteEn}, 32'h1);
        step();
        ctl_reset = 1'b0;
        check_eq("abort_state", {cmd_ready, rsp_valid, ctl_load1, ctl_load2, 28'(ctl_cmd_count)},
                 {4'b1000, 28'h0});
        step();
        check_eq("abort_idle", {31'h0, cmd_ready}, 32'h1);

        // Back-to-back with both handshakes held high; counter wraps at 4.
        cmd_valid = 1'b1; rsp_ready = 1'b1; cmd_rd_only = 1'b0; cmd_op = 3'b000;
        for (int k = 0; k < 4; k++) begin
            cmd_a = 32'(k + 1); cmd_b = 32'(100 * k); cmd_addr = 5'(4 + k);
            step();
            check_eq("b2b_accept", {30'h0, ctl_load1, cmd_ready}, 32'h2);
            for (int c = 0; c < 4; c++) begin
                step();
                check_eq("b2b_busy", {30'h0, cmd_ready, rsp_valid}, (c == 3) ? 32'h1 : 32'h0);
            end
            check_eq("b2b_data", rsp_data, 32'(101 * k + 1));
            if (k == 3) cmd_valid = 1'b0;
            step();
            check_eq("b2b_count", {29'h0, cmd_ready, ctl_cmd_count}, {29'h0, 1'b1, 2'(k + 1)});
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;

        do_cmd(1'b1, 3'b000, 32'd0, 32'd0, 5'd2, 32'd34, 0, 2'd1);
        do_cmd(1'b1, 3'b000, 32'd0, 32'd0, 5'd6, 32'd203, 0, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
